// File: rtl/delay_pkg.sv
// Shared helpers for the delay-line family: depth legality check and
// pointer/delay width derivation.
package delay_pkg;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unsigned delay_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/delay_ram.sv
// DEPTH x N distributed RAM: one synchronous write port, one asynchronous
// read port.
module delay_ram #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // NOTE: no reset on the array -- a reset would prevent LUT-RAM mapping;
  // stale contents are masked by the valid logic in the parent.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line over a circular buffer.
// Define VAR_DELAY_OREG_EN to add one registered output stage.
module var_delay_line
  import delay_pkg::*;
#(
  parameter int N          = 8,
  parameter int MAX_DELAY  = 16,
  parameter int DELAY_INIT = 4,
  parameter int AW         = delay_w(MAX_DELAY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [N-1:0]  i_data,
  input  logic          i_load,
  input  logic [AW-1:0] i_delay,
  output logic [N-1:0]  o_data,
  output logic          o_valid,
  output logic [AW-1:0] o_delay
);

  if (!is_pow2(MAX_DELAY) || MAX_DELAY < 2) begin : g_bad_depth
    $error("var_delay_line: MAX_DELAY must be a power of two and >= 2");
  end
  if (DELAY_INIT < 0 || DELAY_INIT >= MAX_DELAY) begin : g_bad_init
    $error("var_delay_line: DELAY_INIT out of range");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] d_reg;
  logic [AW:0]   fill;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic [N-1:0]  data_c;
  logic          valid_c;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      d_reg  <= AW'(DELAY_INIT);
      fill   <= '0;
    end else begin
      if (ce) wr_ptr <= wr_ptr + AW'(1);
      if (i_load) begin
        d_reg <= i_delay;
        // A sample accepted on the load edge already counts toward the new delay.
        fill  <= (ce && i_delay != '0) ? (AW+1)'(1) : '0;
      end else if (ce && fill < {1'b0, d_reg}) begin
        fill <= fill + (AW+1)'(1);
      end
    end
  end

  // Modulo-2^AW subtraction wraps naturally at the buffer boundary.
  assign rd_addr = wr_ptr - d_reg;

  delay_ram #(
    .N     (N),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ce && !rst),
    .waddr (wr_ptr),
    .wdata (i_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: defaults first so no path through always_comb infers a latch.
  always_comb begin
    valid_c = (fill >= {1'b0, d_reg});
    data_c  = '0;
    if (d_reg == '0)  data_c = i_data;
    else if (valid_c) data_c = rd_data;
  end

`ifdef VAR_DELAY_OREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_data  <= data_c;
      o_valid <= valid_c;
    end
  end
`else
  assign o_data  = data_c;
  assign o_valid = valid_c;
`endif

  assign o_delay = d_reg;

endmodule
